bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator_pkg.sv | 46 ++++
 rtl/bus_watchdog.sv | 32 +++
 rtl/bus_initiator.sv | 125 ++++++++++++
 tb/tb_bus_initiator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_initiator_pkg.sv
// Purpose: shared types for the bus initiator and the bus decoder (states, status codes, lane select).
// Latency: n/a (types and one pure helper function).
// Backpressure: n/a.
// Contents: state_e, err_e, lane_e, cmd_t, lane_sel().
package bus_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ALIGN   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    // Bit 1 drives UDS (even byte, DATA[15:8]); bit 0 drives LDS (odd byte, DATA[7:0]).
    typedef enum logic [1:0] {
        LANE_NONE  = 2'b00,
        LANE_LOWER = 2'b01,
        LANE_UPPER = 2'b10,
        LANE_BOTH  = 2'b11
    } lane_e;

    typedef struct packed {
        logic        wr;
        logic        word;
        logic [23:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    function automatic lane_e lane_sel(input logic word, input logic a0);
        if (word) begin
            return LANE_BOTH;
        end else if (a0) begin
            return LANE_LOWER;
        end else begin
            return LANE_UPPER;
        end
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Purpose: counts clocks spent waiting for an acknowledge; flags when the TIMEOUT-th wait cycle is reached.
// Latency: o_expired is combinational from the count; the count starts at 0 on the first enabled cycle.
// Backpressure: none; the count saturates at TIMEOUT-1 while enabled.
// Ports: i_clk, i_rst_n (async active-low), i_clear, i_enable, o_expired.
module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Expiry is qualified by enable so a stale count can never abort a fresh cycle.
    assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/bus_initiator.sv
// Purpose: runs one asynchronous-style bus cycle (address, strobes, data, DTACK handshake) per accepted command.
// Latency: zero-wait read/write gives DONE in the 4th cycle after acceptance; misaligned word gives DONE in the 1st.
// Backpressure: READY=1 only in IDLE; REQ_IN while busy is dropped, never queued.
// Ports: command side REQ_*/READY/DONE/RDATA/ERR; bus side AS/WR/UDS/LDS/ADDR/DATA/DTACK_IN.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        CPUCLK_IN,
    input  logic        RUN_IN,
    input  logic        REQ_IN,
    input  logic        REQ_WR_IN,
    input  logic        REQ_WORD_IN,
    input  logic [23:0] REQ_ADDR_IN,
    input  logic [15:0] REQ_WDATA_IN,
    output logic        READY,
    output logic        DONE,
    output logic [15:0] RDATA,
    output logic [1:0]  ERR,
    output logic        AS,
    output logic        WR,
    output logic        UDS,
    output logic        LDS,
    output logic [23:0] ADDR,
    inout  wire  [15:0] DATA,
    input  logic        DTACK_IN
);

    state_e      r_state;
    state_e      w_next;
    cmd_t        r_cmd;
    err_e        r_err;
    logic [15:0] r_rdata;

    logic        w_accept;
    logic        w_align;
    logic        w_expired;
    logic        w_drive;
    lane_e       w_lane;
    logic [15:0] w_wdata;
    logic [15:0] w_rd_lane;

    assign w_accept = (r_state == ST_IDLE) && REQ_IN;
    assign w_align  = REQ_WORD_IN && REQ_ADDR_IN[0];

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (CPUCLK_IN),
        .i_rst_n   (RUN_IN),
        .i_clear   (r_state != ST_WAIT),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (REQ_IN) w_next = w_align ? ST_FIN : ST_ADDR;
            ST_ADDR:    w_next = ST_WAIT;
            // Acknowledge wins over expiry when both land on the same edge.
            ST_WAIT:    if (DTACK_IN || w_expired) w_next = ST_RELEASE;
            // Hold until the responder withdraws, so a stale DTACK cannot leak into the next cycle.
            ST_RELEASE: if (!DTACK_IN) w_next = ST_FIN;
            ST_FIN:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Byte reads are zero-extended from the addressed lane.
    always_comb begin
        w_rd_lane = DATA;
        if (!r_cmd.word) begin
            w_rd_lane = r_cmd.addr[0] ? {8'h00, DATA[7:0]} : {8'h00, DATA[15:8]};
        end
    end

    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_cmd   <= '0;
            r_err   <= ERR_OK;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cmd <= '{wr: REQ_WR_IN, word: REQ_WORD_IN, addr: REQ_ADDR_IN, wdata: REQ_WDATA_IN};
                r_err <= w_align ? ERR_ALIGN : ERR_OK;
            end
            if (r_state == ST_WAIT) begin
                if (DTACK_IN) begin
                    if (!r_cmd.wr) begin
                        r_rdata <= w_rd_lane;
                    end
                end else if (w_expired) begin
                    r_err <= ERR_TIMEOUT;
                end
            end
        end
    end

    assign w_lane  = lane_sel(r_cmd.word, r_cmd.addr[0]);
    // Byte writes put the byte on both lanes; the strobe tells the responder which one counts.
    assign w_wdata = r_cmd.word ? r_cmd.wdata : {r_cmd.wdata[7:0], r_cmd.wdata[7:0]};
    assign w_drive = r_cmd.wr && ((r_state == ST_ADDR) || (r_state == ST_WAIT));

    assign READY = (r_state == ST_IDLE);
    assign DONE  = (r_state == ST_FIN);
    assign ERR   = DONE ? r_err : ERR_OK;
    assign RDATA = r_rdata;
    assign AS    = (r_state == ST_WAIT);
    assign UDS   = AS && w_lane[1];
    assign LDS   = AS && w_lane[0];
    assign WR    = w_drive;
    assign ADDR  = r_cmd.addr;
    assign DATA  = w_drive ? w_wdata : 16'bz;

endmodule

// File: tb/tb_bus_initiator.sv
`timescale 1ns/1ps
module tb_bus_initiator;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_word = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        ready, done, as_o, wr_o, uds, lds;
    logic [15:0] rdata;
    logic [1:0]  err;
    logic [23:0] addr_o;
    logic        dtack = 1'b0;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_dat = '0;
    wire  [15:0] bus_data;

    assign bus_data = tb_drv ? tb_dat : 16'bz;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT(TMO)) dut (
        .CPUCLK_IN    (clk),
        .RUN_IN       (rst_n),
        .REQ_IN       (req),
        .REQ_WR_IN    (req_wr),
        .REQ_WORD_IN  (req_word),
        .REQ_ADDR_IN  (req_addr),
        .REQ_WDATA_IN (req_wdata),
        .READY        (ready),
        .DONE         (done),
        .RDATA        (rdata),
        .ERR          (err),
        .AS           (as_o),
        .WR           (wr_o),
        .UDS          (uds),
        .LDS          (lds),
        .ADDR         (addr_o),
        .DATA         (bus_data),
        .DTACK_IN     (dtack)
    );

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [1:0]  lanes;
        logic [15:0] bus;
        logic [1:0]  err;
        logic [15:0] rdata;
        int          as_cyc;
        int          wr_cyc;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic [15:0] model_rdata = '0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Responder: acknowledges after resp_w wait cycles of AS, drives read data
    // while AS is up, and optionally keeps DTACK for resp_h cycles after AS drops.
    int          resp_w = 0;
    int          resp_h = 0;
    logic [15:0] resp_d = '0;
    initial begin
        int wcnt;
        int hcnt;
        wcnt = 0;
        hcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (as_o) begin
                wcnt++;
                hcnt   = resp_h;
                dtack  = (wcnt > resp_w);
                tb_drv = !wr_o;
                tb_dat = resp_d;
            end else begin
                wcnt   = 0;
                tb_drv = 1'b0;
                if (dtack && hcnt > 0) hcnt--;
                else dtack = 1'b0;
            end
        end
    end

    // Monitor: accumulates bus behaviour of the current command, compares at DONE.
    initial begin
        exp_t e;
        int   m_as;
        int   m_wr;
        int   m_bad;
        m_as = 0;
        m_wr = 0;
        m_bad = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_as = 0;
                m_wr = 0;
                m_bad = 0;
            end else begin
                if (wr_o) m_wr++;
                if (as_o) begin
                    m_as++;
                    if (exp_q.size() == 0) m_bad++;
                    else begin
                        e = exp_q[0];
                        if ({uds, lds} != e.lanes || addr_o != e.addr || wr_o != e.wr ||
                            (e.wr && bus_data != e.bus)) m_bad++;
                    end
                end else if (uds || lds) begin
                    m_bad++;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_done: got DONE expected none at cycle %0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("err", err, e.err);
                        check("rdata", rdata, e.rdata);
                        check("latency", cyc - e.acc + 1, e.lat);
                        check("as_cycles", m_as, e.as_cyc);
                        check("wr_cycles", m_wr, e.wr_cyc);
                        check("bus_strobe_addr_data_errors", m_bad, 0);
                    end
                    m_as = 0;
                    m_wr = 0;
                    m_bad = 0;
                end
            end
        end
    end

    // Issue one command; the reference model is evaluated here from the protocol
    // rules (wait count vs timeout, lane choice) and pushed to the scoreboard.
    task automatic issue(input logic wr, input logic word, input logic [23:0] a,
                         input logic [15:0] wd, input int w, input int h, input logic [15:0] rd);
        exp_t e;
        int   n;
        int   rel;
        n = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("ready_wait_expired", 0, 1);
            return;
        end
        resp_w = w;
        resp_h = h;
        resp_d = rd;
        e.wr    = wr;
        e.addr  = a;
        e.lanes = word ? 2'b11 : (a[0] ? 2'b01 : 2'b10);
        e.bus   = word ? wd : {wd[7:0], wd[7:0]};
        e.acc   = cyc + 1;
        if (word && a[0]) begin
            e.err = 2'd1;
            e.as_cyc = 0;
            e.lat = 1;
        end else if (w < TMO) begin
            e.err = 2'd0;
            e.as_cyc = w + 1;
            rel = 1 + h;
            e.lat = 1 + e.as_cyc + rel + 1;
            if (!wr) model_rdata = word ? rd : (a[0] ? {8'h00, rd[7:0]} : {8'h00, rd[15:8]});
        end else begin
            e.err = 2'd2;
            e.as_cyc = TMO;
            e.lat = 1 + TMO + 1 + 1;
        end
        e.wr_cyc = (wr && !(word && a[0])) ? 1 + e.as_cyc : 0;
        e.rdata  = model_rdata;
        exp_q.push_back(e);
        req = 1'b1;
        req_wr = wr;
        req_word = word;
        req_addr = a;
        req_wdata = wd;
        @(negedge clk);
        // Request held with junk while busy: must be ignored, not queued.
        if ($urandom_range(0, 1) == 1) begin
            req_wr = 1'($urandom);
            req_word = 1'($urandom);
            req_addr = 24'($urandom);
            req_wdata = 16'($urandom);
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    initial begin
        int n;
        logic        word;
        logic [23:0] a;
        #1;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_as", as_o, 0);
        check("reset_wr", wr_o, 0);
        check("reset_uds", uds, 0);
        check("reset_lds", lds, 0);
        check("reset_addr", addr_o, 0);
        check("reset_err", err, 0);
        check("reset_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(1, 1, 24'h000100, 16'hBEEF, 0, 0, 16'h0000);
        issue(0, 0, 24'h100003, 16'h0000, 3, 0, 16'h005A);
        issue(1, 0, 24'h000005, 16'h0012, 1, 0, 16'h0000);
        issue(0, 1, 24'h000101, 16'h0000, 0, 0, 16'h1234);
        issue(0, 1, 24'hF00000, 16'h0000, 1000, 0, 16'hFFFF);
        issue(0, 1, 24'h000200, 16'h0000, TMO - 1, 0, 16'hA5C3);
        issue(0, 0, 24'h000202, 16'h0000, TMO, 0, 16'h7E7E);
        issue(0, 0, 24'h000300, 16'h0000, 0, 3, 16'hC4D5);
        issue(1, 1, 24'h000400, 16'h1357, 2, 2, 16'h0000);

        // Reset during WAIT of a write: strobes drop at once, no DONE follows.
        issue(1, 1, 24'h000600, 16'hCAFE, 1000, 0, 16'h0000);
        repeat (3) @(negedge clk);
        check("as_before_reset", as_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_as", as_o, 0);
        check("arst_wr", wr_o, 0);
        check("arst_uds", uds, 0);
        check("arst_lds", lds, 0);
        check("arst_done", done, 0);
        check("arst_ready", ready, 1);
        check("arst_rdata", rdata, 0);
        void'(exp_q.pop_back());
        model_rdata = '0;
        resp_w = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 80; i++) begin
            word = 1'($urandom);
            a = 24'($urandom);
            if (word && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            issue(1'($urandom), word, a, 16'($urandom), $urandom_range(0, TMO + 2),
                  $urandom_range(0, 2), 16'($urandom));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
